// File: rtl/pipe_load_ctrl_pkg.sv
// rtl/pipe_load_ctrl_pkg.sv - shared drain FSM encoding and default widths for the pipe load controller
package pipe_ctrl_pkg;

  localparam int STALL_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_DRAIN      = 2'd1,
    ST_DONE       = 2'd2,
    ST_DRAIN_HOLD = 2'd3
  } drain_state_t;

endpackage

// File: rtl/pipe_load_ctrl_if.sv
// rtl/pipe_load_ctrl_if.sv - handshake, control and status bundle between the pipe load controller and its user
interface pipe_load_ctrl_if #(
  parameter int PIPELINE_STAGE = 5,
  parameter int OCC_W          = $clog2(PIPELINE_STAGE + 1),
  parameter int STALL_CNT_W    = pipe_ctrl_pkg::STALL_CNT_W_DEF
);

  logic                      in_valid_i;
  logic                      in_ready_o;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [PIPELINE_STAGE-1:0] pipeLoad_en_o;
  logic [PIPELINE_STAGE-1:0] stage_valid_o;
  logic                      flush_i;
  logic                      drain_req_i;
  logic                      drain_done_o;
  logic [OCC_W-1:0]          occupancy_o;
  logic [STALL_CNT_W-1:0]    stall_cnt_o;
  logic                      stall_clr_i;

  modport master (
    output in_valid_i, out_ready_i, flush_i, drain_req_i, stall_clr_i,
    input  in_ready_o, out_valid_o, pipeLoad_en_o, stage_valid_o,
           drain_done_o, occupancy_o, stall_cnt_o
  );

  modport slave (
    input  in_valid_i, out_ready_i, flush_i, drain_req_i, stall_clr_i,
    output in_ready_o, out_valid_o, pipeLoad_en_o, stage_valid_o,
           drain_done_o, occupancy_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_load_ctrl_ready_chain.sv
// rtl/pipe_load_ctrl_ready_chain.sv - combinational elastic ready chain: a stage may load when it or any stage ahead has room
module pipe_ready_chain #(
  parameter int PIPELINE_STAGE = 5
) (
  input  logic [PIPELINE_STAGE-1:0] i_v,
  input  logic                      i_out_ready,
  output logic [PIPELINE_STAGE-1:0] o_rdy
);

  logic w_acc;

  // Walk from the output backwards so each stage sees the room available downstream of it.
  always_comb begin
    w_acc = i_out_ready;
    o_rdy = '0;
    for (int s = PIPELINE_STAGE - 1; s >= 0; s--) begin
      w_acc    = !i_v[s] | w_acc;
      o_rdy[s] = w_acc;
    end
  end

endmodule

// File: rtl/pipe_load_ctrl.sv
// rtl/pipe_load_ctrl.sv - elastic load-enable controller with flush, drain handshake, occupancy and stall counting
module pipe_load_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PIPELINE_STAGE = 5,
  parameter int OCC_W          = $clog2(PIPELINE_STAGE + 1),
  parameter int STALL_CNT_W    = STALL_CNT_W_DEF
) (
  input logic             sys_clk,
  input logic             rstn,
  pipe_load_ctrl_if.slave bus
);

  localparam int N = PIPELINE_STAGE;

  drain_state_t           r_state;
  drain_state_t           w_state_nxt;
  logic [N-1:0]           r_v;
  logic [N-1:0]           w_v_nxt;
  logic [N-1:0]           w_rdy;
  logic [OCC_W-1:0]       r_occ;
  logic [OCC_W-1:0]       w_occ_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_intake_ok;
  logic                   w_drain_done;

  pipe_ready_chain #(.PIPELINE_STAGE(N)) u_ready_chain (
    .i_v         (r_v),
    .i_out_ready (bus.out_ready_i),
    .o_rdy       (w_rdy)
  );

  // Bubbles are loaded too; the datapath ignores contents of invalid stages.
  always_comb begin
    w_v_nxt = r_v;
    if (bus.flush_i) begin
      w_v_nxt = '0;
    end else begin
      if (w_rdy[0]) w_v_nxt[0] = bus.in_valid_i & w_intake_ok;
      for (int s = 1; s < N; s++) begin
        if (w_rdy[s]) w_v_nxt[s] = r_v[s-1];
      end
    end
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int s = 0; s < N; s++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[s]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_v   <= '0;
      r_occ <= '0;
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn || bus.stall_clr_i) begin
      r_stall_cnt <= '0;
    end else if (r_v[N-1] && !bus.out_ready_i && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Emptiness is judged on the next valid vector so an already-empty pipe completes in one cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.drain_req_i) w_state_nxt = (w_v_nxt == '0) ? ST_DONE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.drain_req_i)     w_state_nxt = ST_RUN;
          else if (w_v_nxt == '0)   w_state_nxt = ST_DONE;
        end
        ST_DONE:       w_state_nxt = bus.drain_req_i ? ST_DRAIN_HOLD : ST_RUN;
        ST_DRAIN_HOLD: if (!bus.drain_req_i) w_state_nxt = ST_RUN;
        default:       w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_intake_ok  = (r_state == ST_RUN) && !bus.drain_req_i;
    w_drain_done = (r_state == ST_DONE);
  end

  assign bus.in_ready_o    = w_rdy[0] & w_intake_ok & !bus.flush_i & rstn;
  assign bus.pipeLoad_en_o = w_rdy & {N{rstn}};
  assign bus.stage_valid_o = r_v;
  assign bus.out_valid_o   = r_v[N-1];
  assign bus.occupancy_o   = r_occ;
  assign bus.stall_cnt_o   = r_stall_cnt;
  assign bus.drain_done_o  = w_drain_done;

endmodule

// File: tb/tb_pipe_load_ctrl.sv
// tb/tb_pipe_load_ctrl.sv - directed bench with a slot-level pipeline model and a bench-side data register chain
module tb_pipe_load_ctrl;

  localparam int N  = 5;
  localparam int SW = 4;
  localparam int P_RUN = 0, P_DRAIN = 1, P_DONE = 2, P_HOLD = 3;

  logic       sys_clk = 1'b0;
  logic       rstn    = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic [7:0] dp [N];

  int checks = 0;
  int errors = 0;
  int got[$];
  int pulses = 0;

  bit [N-1:0] mv = '0;
  int         md [N];
  int         m_occ = 0, m_stall = 0, m_phase = P_RUN;
  bit         known = 1'b0;

  pipe_load_ctrl_if #(.PIPELINE_STAGE(N), .STALL_CNT_W(SW)) bus ();

  pipe_load_ctrl #(.PIPELINE_STAGE(N), .STALL_CNT_W(SW)) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // Datapath register chain that the controller's enables steer.
  always @(posedge sys_clk) begin
    for (int s = N - 1; s >= 1; s--) if (bus.pipeLoad_en_o[s]) dp[s] <= dp[s-1];
    if (bus.pipeLoad_en_o[0]) dp[0] <= in_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic check_got(input string name, input int first, input int n);
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], first + i);
  endtask

  // Model: find the highest free slot (the top counts as free when it is consumed); everything below it shifts up.
  initial begin : cmp
    int         b;
    bit         intake;
    bit [N-1:0] nv;
    int         nd [N];
    logic [N-1:0] exp_en;
    forever begin
      @(negedge sys_clk);
      if (known) begin
        chk("stage_valid", bus.stage_valid_o, mv);
        chk("out_valid", bus.out_valid_o, mv[N-1]);
        chk("occupancy", bus.occupancy_o, m_occ);
        chk("stall_cnt", bus.stall_cnt_o, m_stall);
        chk("drain_done", bus.drain_done_o, m_phase == P_DONE);
        if (mv[N-1]) chk("out_data", dp[N-1], md[N-1]);
      end
      if (rstn && bus.out_valid_o === 1'b1 && bus.out_ready_i) got.push_back(int'(dp[N-1]));
      if (bus.drain_done_o === 1'b1) pulses++;
      if (!rstn) begin
        chk("rst_in_ready", bus.in_ready_o, 0);
        chk("rst_load_en", bus.pipeLoad_en_o, 0);
        mv = '0; m_occ = 0; m_stall = 0; m_phase = P_RUN; known = 1'b1;
      end else begin
        intake = (m_phase == P_RUN) && !bus.drain_req_i && !bus.flush_i;
        b = -1;
        for (int s = N - 1; s >= 0; s--) begin
          if (b < 0 && (!mv[s] || (s == N - 1 && bus.out_ready_i))) b = s;
        end
        for (int s = 0; s < N; s++) exp_en[s] = (s <= b);
        chk("in_ready", bus.in_ready_o, (b >= 0) && intake);
        chk("load_en", bus.pipeLoad_en_o, exp_en);
        if (bus.stall_clr_i) m_stall = 0;
        else if (mv[N-1] && !bus.out_ready_i && m_stall < (1 << SW) - 1) m_stall++;
        nv = mv;
        nd = md;
        if (bus.flush_i) begin
          nv = '0;
        end else if (b >= 0) begin
          for (int s = b; s >= 1; s--) begin
            nv[s] = mv[s-1];
            nd[s] = md[s-1];
          end
          nv[0] = bus.in_valid_i && intake;
          nd[0] = int'(in_data);
        end
        if (bus.flush_i) m_phase = P_RUN;
        else case (m_phase)
          P_RUN:   if (bus.drain_req_i) m_phase = (nv == 0) ? P_DONE : P_DRAIN;
          P_DRAIN: if (!bus.drain_req_i) m_phase = P_RUN; else if (nv == 0) m_phase = P_DONE;
          P_DONE:  m_phase = bus.drain_req_i ? P_HOLD : P_RUN;
          default: if (!bus.drain_req_i) m_phase = P_RUN;
        endcase
        mv = nv;
        md = nd;
        m_occ = $countones(nv);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin : stim
    int acc;
    bus.in_valid_i = 0; bus.out_ready_i = 0; bus.flush_i = 0;
    bus.drain_req_i = 0; bus.stall_clr_i = 0;
    repeat (2) step();
    rstn = 1'b1;
    #1;
    chk("reset_occ", bus.occupancy_o, 0);
    chk("reset_valid", bus.stage_valid_o, 0);
    chk("reset_stall", bus.stall_cnt_o, 0);

    // Streaming: first output N cycles after the first handshake, no gaps.
    got.delete();
    bus.out_ready_i = 1; bus.in_valid_i = 1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 8'(i);
      step();
      chk("stream_latency", bus.out_valid_o, i >= 5);
    end
    bus.in_valid_i = 0;
    repeat (8) step();
    check_got("stream_data", 1, 10);
    chk("stream_stall", bus.stall_cnt_o, 0);

    // Backpressure with bubble collapse.
    got.delete();
    bus.out_ready_i = 0; bus.in_valid_i = 1; in_data = 8'd21;
    step();
    bus.in_valid_i = 0;
    repeat (2) step();
    bus.in_valid_i = 1; in_data = 8'd22;
    step();
    bus.in_valid_i = 0;
    repeat (4) step();
    chk("bp_packed", bus.stage_valid_o, 5'b11000);
    chk("bp_occ2", bus.occupancy_o, 2);
    bus.in_valid_i = 1;
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      in_data = 8'(23 + acc);
      #1;
      if (bus.in_ready_o) acc++;
      step();
    end
    #1;
    chk("bp_accepted", acc, 3);
    chk("bp_full_ready", bus.in_ready_o, 0);
    chk("bp_full_occ", bus.occupancy_o, 5);
    chk("bp_full_en", bus.pipeLoad_en_o, 0);
    chk("bp_stall", bus.stall_cnt_o, 9);
    bus.in_valid_i = 0; bus.out_ready_i = 1;
    repeat (7) step();
    check_got("bp_data", 21, 5);
    chk("bp_stall_after", bus.stall_cnt_o, 9);

    // Flush with a concurrent input offer.
    got.delete();
    bus.out_ready_i = 0; bus.in_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(31 + i);
      step();
    end
    chk("flush_pre_occ", bus.occupancy_o, 3);
    in_data = 8'd34; bus.flush_i = 1;
    #1;
    chk("flush_in_ready", bus.in_ready_o, 0);
    step();
    bus.flush_i = 0; bus.in_valid_i = 0;
    #1;
    chk("flush_valid", bus.stage_valid_o, 0);
    chk("flush_occ", bus.occupancy_o, 0);
    bus.out_ready_i = 1;
    repeat (6) step();
    check_got("flush_data", 0, 0);

    // Drain of four in-flight data, then hold until the request drops.
    got.delete();
    bus.out_ready_i = 0; bus.in_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(41 + i);
      step();
    end
    in_data = 8'd45; bus.drain_req_i = 1;
    #1;
    chk("drain_in_ready", bus.in_ready_o, 0);
    chk("drain_occ4", bus.occupancy_o, 4);
    pulses = 0;
    bus.out_ready_i = 1;
    repeat (10) step();
    chk("drain_pulses", pulses, 1);
    check_got("drain_data", 41, 4);
    #1;
    chk("drain_hold_ready", bus.in_ready_o, 0);
    bus.drain_req_i = 0; bus.in_valid_i = 0;
    step();
    #1;
    chk("drain_resume_ready", bus.in_ready_o, 1);

    // Drain on an empty pipe completes one cycle after the request.
    bus.drain_req_i = 1;
    step();
    chk("empty_drain_pulse", bus.drain_done_o, 1);
    step();
    chk("empty_drain_single", bus.drain_done_o, 0);
    bus.drain_req_i = 0;
    step();

    // Reset in the middle of a drain.
    bus.out_ready_i = 0; bus.in_valid_i = 1; in_data = 8'd51;
    step();
    in_data = 8'd52;
    step();
    bus.in_valid_i = 0; bus.drain_req_i = 1;
    step();
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", bus.in_ready_o, 0);
    chk("mid_rst_en", bus.pipeLoad_en_o, 0);
    step();
    chk("mid_rst_valid", bus.stage_valid_o, 0);
    chk("mid_rst_occ", bus.occupancy_o, 0);
    chk("mid_rst_stall", bus.stall_cnt_o, 0);
    chk("mid_rst_done", bus.drain_done_o, 0);
    rstn = 1'b1; bus.drain_req_i = 0;
    #1;
    chk("mid_rst_run", bus.in_ready_o, 1);

    // Stall counter saturation and clear priority.
    bus.in_valid_i = 1; in_data = 8'd61;
    step();
    bus.in_valid_i = 0;
    repeat (25) step();
    chk("stall_sat", bus.stall_cnt_o, 15);
    bus.stall_clr_i = 1;
    step();
    bus.stall_clr_i = 0;
    chk("stall_clr", bus.stall_cnt_o, 0);

    bus.flush_i = 1;
    step();
    bus.flush_i = 0; bus.out_ready_i = 1;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
